regfile_writeback: RTL and testbench

Writeback-side driver of the core's 32×32 register file. Accepts ALU results and in-order data-memory load responses, formats load data (byte/half/word, signed/unsigned), arbitrates both sources onto the single register-file write port, and keeps a pending-load scoreboard. Decode uses the scoreboard to stall on load-use hazards. Sits between the execute/memory stages and the register file's write port.

---
 rtl/regfile_writeback.sv | 156 +++++++++++++++
 tb/tb_regfile_writeback.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register-file writeback: arbitrates ALU results and in-order load responses onto one write port.
// Optional WB_BYPASS_EN exposes the combinational winning write as byp_* forwarding outputs.
module regfile_writeback #(
  parameter int unsigned LD_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_issue_valid,
  input  logic [4:0]  ld_issue_rd,
  input  logic [2:0]  ld_issue_funct3,
  input  logic [1:0]  ld_issue_off,
  output logic        ld_issue_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
`ifdef WB_BYPASS_EN
  output logic        byp_valid,
  output logic [4:0]  byp_rd,
  output logic [31:0] byp_data,
`endif
  output logic        resp_err
);

  localparam int unsigned PtrW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(LD_DEPTH + 1);

  logic [4:0]      fifo_rd  [LD_DEPTH];
  logic [2:0]      fifo_f3  [LD_DEPTH];
  logic [1:0]      fifo_off [LD_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     sb_q, sb_d;
  logic            err_q, err_d;
  logic            we_q;
  logic [4:0]      rd_q;
  logic [31:0]     wdata_q;

  logic            full, empty, push, pop;
  logic [4:0]      head_rd;
  logic [2:0]      head_f3;
  logic [1:0]      head_off;
  logic [31:0]     shifted, ld_data;
  logic            wr_sel;
  logic [4:0]      wr_rd;
  logic [31:0]     wr_data;

  assign full     = (cnt_q == CntW'(LD_DEPTH));
  assign empty    = (cnt_q == '0);
  assign head_rd  = fifo_rd[rd_ptr_q];
  assign head_f3  = fifo_f3[rd_ptr_q];
  assign head_off = fifo_off[rd_ptr_q];

  // Ready uses current occupancy only, so a same-cycle pop does not free a slot.
  assign ld_issue_ready = ~full & ~((ld_issue_rd != 5'd0) & sb_q[ld_issue_rd]);
  assign push           = ld_issue_valid & ld_issue_ready;
  assign pop            = mem_rvalid & ~empty;
  assign alu_ready      = ~pop;

  assign rs1_busy = (rs1_addr != 5'd0) & sb_q[rs1_addr];
  assign rs2_busy = (rs2_addr != 5'd0) & sb_q[rs2_addr];

  always_comb begin
    shifted = mem_rdata >> {head_off, 3'b000};
    case (head_f3)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_comb begin
    wr_sel  = 1'b0;
    wr_rd   = alu_rd;
    wr_data = alu_data;
    if (pop) begin
      wr_sel  = 1'b1;
      wr_rd   = head_rd;
      wr_data = ld_data;
    end else if (alu_valid) begin
      wr_sel  = 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_valid = wr_sel & (wr_rd != 5'd0);
  assign byp_rd    = wr_rd;
  assign byp_data  = wr_data;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    sb_d     = sb_q;
    err_d    = err_q | (mem_rvalid & empty);
    if (push) wr_ptr_d = (LD_DEPTH == 1) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (LD_DEPTH == 1) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
    // Clear before set so a same-cycle set of the same bit wins.
    if (pop) sb_d[head_rd] = 1'b0;
    if (push && (ld_issue_rd != 5'd0)) sb_d[ld_issue_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      sb_q     <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      rd_q     <= 5'd0;
      wdata_q  <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      sb_q     <= sb_d;
      err_q    <= err_d;
      we_q     <= wr_sel & (wr_rd != 5'd0);
      if (wr_sel) begin
        rd_q    <= wr_rd;
        wdata_q <= wr_data;
      end
    end
  end

  // Entry storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_rd[wr_ptr_q]  <= ld_issue_rd;
      fifo_f3[wr_ptr_q]  <= ld_issue_funct3;
      fifo_off[wr_ptr_q] <= ld_issue_off;
    end
  end

  assign rf_we    = we_q;
  assign rf_rd    = rd_q;
  assign rf_wdata = wdata_q;
  assign resp_err = err_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: expected writes queued at acceptance, popped on rf_we.
module tb_regfile_writeback;
  localparam int unsigned LD_DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue_valid, ld_issue_ready;
  logic [4:0]  ld_issue_rd;
  logic [2:0]  ld_issue_funct3;
  logic [1:0]  ld_issue_off;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        resp_err;
`ifdef WB_BYPASS_EN
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;
`endif

  regfile_writeback #(.LD_DEPTH(LD_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd),
    .ld_issue_funct3(ld_issue_funct3), .ld_issue_off(ld_issue_off),
    .ld_issue_ready(ld_issue_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
`ifdef WB_BYPASS_EN
    .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
`endif
    .resp_err(resp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] off;
  } pend_t;

  pend_t       pend[$];
  logic [36:0] exp_q[$];
  logic        model_err;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] off,
                                      input logic [31:0] d);
    logic [31:0] w;
    w = d;
    for (int i = 0; i < int'(off); i++) w = {8'd0, w[31:8]};
    if (f3 == 3'b000)      return {{24{w[7]}}, w[7:0]};
    else if (f3 == 3'b100) return {24'd0, w[7:0]};
    else if (f3 == 3'b001) return {{16{w[15]}}, w[15:0]};
    else if (f3 == 3'b101) return {16'd0, w[15:0]};
    return w;
  endfunction

  function automatic logic model_busy(input logic [4:0] rd);
    if (rd == 5'd0) return 1'b0;
    foreach (pend[i]) if (pend[i].rd == rd) return 1'b1;
    return 1'b0;
  endfunction

  // Entered at posedge+1; drives one cycle, predicts readies/busy, updates the model.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic iv, input logic [4:0] ird, input logic [2:0] f3,
                       input logic [1:0] off, input logic rv, input logic [31:0] rdata,
                       input logic [4:0] q1, input logic [4:0] q2);
    logic  exp_alu, exp_iss;
    pend_t e;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_issue_valid = iv; ld_issue_rd = ird; ld_issue_funct3 = f3; ld_issue_off = off;
    mem_rvalid = rv; mem_rdata = rdata;
    rs1_addr = q1; rs2_addr = q2;
    #3;
    exp_alu = !(rv && pend.size() > 0);
    exp_iss = (pend.size() < LD_DEPTH) && !model_busy(ird);
    check_eq("alu_ready", alu_ready, exp_alu);
    if (iv) check_eq("ld_issue_ready", ld_issue_ready, exp_iss);
    check_eq("rs1_busy", rs1_busy, model_busy(q1));
    check_eq("rs2_busy", rs2_busy, model_busy(q2));
    if (rv && pend.size() > 0) begin
      e = pend.pop_front();
      if (e.rd != 5'd0) exp_q.push_back({e.rd, fmt(e.f3, e.off, rdata)});
    end else begin
      if (rv) model_err = 1'b1;
      if (av && ard != 5'd0) exp_q.push_back({ard, ad});
    end
    if (iv && exp_iss) pend.push_back('{rd: ird, f3: f3, off: off});
    @(posedge clock);
    #1;
    alu_valid = 1'b0; ld_issue_valid = 1'b0; mem_rvalid = 1'b0;
    check_eq("resp_err", resp_err, model_err);
  endtask

  task automatic idle(input logic [4:0] q1 = 5'd0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, q1, 0);
  endtask
  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    cycle(1, rd, d, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    cycle(0, 0, 0, 1, rd, f3, off, 0, 0, rd, 0);
  endtask
  task automatic resp(input logic [31:0] d);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, d, 0, 0);
  endtask

  always @(negedge clock) begin
    logic [36:0] e;
    if (!reset && rf_we) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_we", {31'd0, rf_we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rf_rd", {27'd0, rf_rd}, {27'd0, e[36:32]});
        check_eq("rf_wdata", rf_wdata, e[31:0]);
      end
    end
  end

  initial begin
    logic [2:0] f3_tab [6];
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    reset = 1'b1; model_err = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue_valid = 0; ld_issue_rd = 0; ld_issue_funct3 = 0; ld_issue_off = 0;
    mem_rvalid = 0; mem_rdata = 0; rs1_addr = 0; rs2_addr = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_eq("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check_eq("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
    check_eq("rst_rf_wdata", rf_wdata, 32'd0);
    check_eq("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check_eq("rst_iss_ready", {31'd0, ld_issue_ready}, 32'd1);
    check_eq("rst_alu_ready", {31'd0, alu_ready}, 32'd1);

    alu(5, 32'hDEADBEEF);
    check_eq("alu_rd5_we", {31'd0, rf_we}, 32'd1);
    alu(0, 32'h12345678);
    check_eq("alu_rd0_we", {31'd0, rf_we}, 32'd0);

    issue(3, 3'b000, 2); resp(32'h0080FF11);
    check_eq("lb_const", rf_wdata, 32'hFFFFFF80);
    issue(4, 3'b100, 2); resp(32'h0080FF11);
    check_eq("lbu_const", rf_wdata, 32'h00000080);
    issue(6, 3'b001, 2); resp(32'h0080FF11);
    check_eq("lh_const", rf_wdata, 32'h00000080);
    issue(8, 3'b101, 0); resp(32'h0080FF11);
    check_eq("lhu_const", rf_wdata, 32'h0000FF11);

    // Load-use and WAW on rd=7.
    issue(7, 3'b010, 0);
    issue(7, 3'b010, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 7, 7);
    idle(7);
    check_eq("rd7_busy_clear", {31'd0, rs1_busy}, 32'd0);

    // Load response beats a same-cycle ALU result.
    issue(9, 3'b010, 0);
    cycle(1, 10, 32'hA1A1A1A1, 0, 0, 0, 0, 1, 32'h99990000, 0, 0);
    check_eq("arb_load_first", {27'd0, rf_rd}, 32'd9);
    alu(10, 32'hA1A1A1A1);
    check_eq("arb_alu_next", {27'd0, rf_rd}, 32'd10);

    // Fill, refuse, refuse with same-cycle response, drain, then stray response.
    issue(11, 3'b010, 0); issue(12, 3'b000, 1);
    issue(13, 3'b010, 0);
    cycle(0, 0, 0, 1, 13, 3'b010, 0, 1, 32'h11111111, 11, 12);
    resp(32'h0000AB00);
    resp(32'h55555555);
    check_eq("stray_err", {31'd0, resp_err}, 32'd1);
    idle();
    idle();

    // Reset drops outstanding loads.
    issue(14, 3'b010, 0); issue(15, 3'b010, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    pend.delete(); model_err = 1'b0;
    rs1_addr = 14; rs2_addr = 15;
    #1;
    check_eq("rst2_busy1", {31'd0, rs1_busy}, 32'd0);
    check_eq("rst2_busy2", {31'd0, rs2_busy}, 32'd0);
    check_eq("rst2_iss_ready", {31'd0, ld_issue_ready}, 32'd1);
    check_eq("rst2_rf_we", {31'd0, rf_we}, 32'd0);
    check_eq("rst2_err", {31'd0, resp_err}, 32'd0);
    @(posedge clock);
    #1;
    issue(14, 3'b001, 1); resp(32'h00F08000);

    // Random mix, keeping rd in a narrow range to provoke hazards.
    for (int i = 0; i < 60; i++) begin
      logic [4:0] r1, r2;
      r1 = 5'($urandom_range(0, 6));
      r2 = 5'($urandom_range(0, 6));
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 6)), $urandom,
            1'($urandom_range(0, 1)), r1, f3_tab[$urandom_range(0, 5)],
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, r1, r2);
    end
    while (pend.size() > 0) resp($urandom);
    idle();
    idle();
    check_eq("exp_q_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
